serial_receiver: RTL and testbench
==================================

// Module: serial_receiver
// PURPOSE
//  Receive side of the inter-board serial link; consumes the bit stream driven by the transmitter.
//  Frame: idle-high line, 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
//  Oversamples the line and reassembles each byte.
//  Presents the byte plus a sticky character_received flag to the microprocessor's parallel input PIO.
// PARAMETERS
//  SAMPLE_DIV       128  clk cycles per sample tick (2^7, the transmitter's minor clock rate)
//  SAMPLES_PER_BIT  16   sample ticks per bit (major/minor ratio 2^11/2^7); even, >=4
// PORTS
//  clk                 in   1  single system clock (CLOCK_50 domain)
//  rst                 in   1  synchronous reset, active-high
//  data_in             in   1  serial line from remote transmitter (GPIO), asynchronous
//  receive_enable      in   1  1 = accept new frames; 0 = stay/return to IDLE after current frame
//  read_ack            in   1  1-cycle pulse from processor: byte consumed
//  data_out            out  8  last received byte
//  character_received  out  1  high from byte capture until read_ack
//  frame_error         out  1  high for last frame if its stop bit sampled 0; updated per frame
//  overrun             out  1  sticky; set if a byte completes while character_received=1; cleared by read_ack
// BEHAVIOUR
//  Reset (rst=1 at posedge clk): all outputs 0.
//   State=IDLE, tick counter=0, sample counter=0, bit counter=0, shift reg=0.
//   Both synchronizer flops preset to 1 (idle line).
//  Sync: data_in passes 2 flops; rx_s = second flop. All decisions use rx_s only.
//  Tick: free-running counter 0..SAMPLE_DIV-1; tick=1 for one clk when it wraps to 0.
//   Counter restarts at 0 on the clk that leaves IDLE, so the first tick is SAMPLE_DIV cycles later.
//  IDLE:  if receive_enable && rx_s==0 -> START; sample ctr=0.
//  START: count ticks. At tick number SAMPLES_PER_BIT/2 (mid start bit):
//   rx_s==0 -> DATA, sample ctr=0, bit ctr=0.
//   rx_s==1 -> glitch, back to IDLE; no output change.
//  DATA:  at every SAMPLES_PER_BIT-th tick (mid-bit), shift rx_s into bit[bit ctr] (LSB first).
//   After bit 7 -> STOP.
//  STOP:  at next mid-bit tick, on the same clk:
//   data_out <= shift reg; frame_error <= ~rx_s.
//   overrun <= overrun | character_received; character_received <= 1.
//   Then -> IDLE.
//   Byte is delivered even on frame error.
//   Next start edge is accepted from the following cycle (back-to-back frames allowed).
//  read_ack: clears character_received and overrun on next posedge.
//   Same cycle as a STOP capture: capture wins; character_received stays 1, overrun is set per the rule above.
//  receive_enable=0 mid-frame: current frame completes normally; IDLE then ignores the line.
//  rst mid-frame: immediate return to IDLE; partial byte discarded; outputs cleared.
//  Line held low forever (break): one frame with frame_error=1 and data_out=8'h00.
//   IDLE waits for rx_s==1 before re-arming (edge-qualified start, not level).
//  Latency: a start-bit falling edge on data_in leads to character_received after
//   2 + ~9.5*SAMPLES_PER_BIT*SAMPLE_DIV clk cycles (±1 tick of edge-detect jitter).
//  Widths: tick ctr $clog2(SAMPLE_DIV); sample ctr $clog2(SAMPLES_PER_BIT); bit ctr 3 bits.
// TESTING  (bench: SAMPLE_DIV=4, SAMPLES_PER_BIT=8, bit period=32 clk)
//  1. Send 8'h74 (start,0,0,1,0,1,1,1,0,stop) -> data_out=8'h74, character_received=1, frame_error=0,
//     at ~306 clk after start edge.
//  2. Send "test" (74,65,73,74) back-to-back, read_ack after each -> 4 bytes in order, overrun=0.
//  3. Send 8'h65 then 8'h73 with no read_ack -> data_out=8'h73, overrun=1.
//     Then read_ack -> character_received=0, overrun=0.
//  4. Stop bit forced 0 on byte 8'hA5 -> data_out=8'hA5, frame_error=1.
//     Next good byte -> frame_error=0.
//  5. 8-clk low glitch on idle line -> state back to IDLE, character_received stays 0.
//  6. rst pulse at mid bit 4 of a frame, then a full frame 8'h3C -> only 8'h3C delivered.
//     Outputs 0 during and after reset.

Source files
------------

// File: rtl/serial_receiver.sv
// Serial line receiver: 8N1 frames, oversampled mid-bit, byte presented with sticky
// character_received / overrun flags and a per-frame frame_error.
module serial_receiver #(
  parameter int SAMPLE_DIV      = 128,
  parameter int SAMPLES_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_in,
  input  logic       receive_enable,
  input  logic       read_ack,
  output logic [7:0] data_out,
  output logic       character_received,
  output logic       frame_error,
  output logic       overrun
);

  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int SW = $clog2(SAMPLES_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic          sync1, rx_s, armed;
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] samp_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          tick, mid_start, mid_bit, start_go, capture;

  assign tick      = (tick_cnt == TW'(SAMPLE_DIV - 1));
  assign mid_start = tick && (samp_cnt == SW'(SAMPLES_PER_BIT/2 - 1));
  assign mid_bit   = tick && (samp_cnt == SW'(SAMPLES_PER_BIT - 1));

  always_comb begin
    state_nxt = state;
    start_go  = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        // armed means rx_s was high last cycle: only a falling edge starts a frame
        if (receive_enable && armed && !rx_s) begin
          state_nxt = START;
          start_go  = 1'b1;
        end
      end
      START: if (mid_start) state_nxt = rx_s ? IDLE : DATA;
      DATA:  if (mid_bit && bit_cnt == 3'd7) state_nxt = STOP;
      STOP: begin
        if (mid_bit) begin
          state_nxt = IDLE;
          capture   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      sync1              <= 1'b1;
      rx_s               <= 1'b1;
      armed              <= 1'b0;
      tick_cnt           <= '0;
      samp_cnt           <= '0;
      bit_cnt            <= '0;
      shreg              <= '0;
      data_out           <= '0;
      character_received <= 1'b0;
      frame_error        <= 1'b0;
      overrun            <= 1'b0;
    end else begin
      sync1 <= data_in;
      rx_s  <= sync1;
      state <= state_nxt;
      armed <= (state == IDLE) && rx_s;

      if (start_go || tick) tick_cnt <= '0;
      else                  tick_cnt <= tick_cnt + TW'(1);

      if (start_go) begin
        samp_cnt <= '0;
        bit_cnt  <= '0;
        shreg    <= '0;
      end else if (tick && state != IDLE) begin
        if ((state == START && mid_start) || mid_bit) samp_cnt <= '0;
        else                                          samp_cnt <= samp_cnt + SW'(1);
        if (state == DATA && mid_bit) begin
          shreg[bit_cnt] <= rx_s;
          bit_cnt        <= bit_cnt + 3'd1;
        end
      end

      // a capture in the same cycle as read_ack takes priority
      if (capture) begin
        data_out           <= shreg;
        frame_error        <= ~rx_s;
        overrun            <= overrun | character_received;
        character_received <= 1'b1;
      end else if (read_ack) begin
        character_received <= 1'b0;
        overrun            <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_receiver.sv
// Bench for serial_receiver: frame-level reference model that schedules each byte's
// arrival from line timing, compared against the DUT outputs every cycle.
module tb_serial_receiver;
  localparam int SAMPLE_DIV = 4;
  localparam int SPB        = 8;
  localparam int BIT_T      = SAMPLE_DIV * SPB;
  localparam int FRAME_T    = 10 * BIT_T;
  // 2 sync flops + 1 IDLE exit, then 9.5 bit periods to the stop-bit middle
  localparam int LAT        = 3 + SAMPLE_DIV * (SPB * 19 / 2);

  logic       clk = 1'b0;
  logic       rst, data_in, receive_enable, read_ack;
  logic [7:0] data_out;
  logic       character_received, frame_error, overrun;

  serial_receiver #(.SAMPLE_DIV(SAMPLE_DIV), .SAMPLES_PER_BIT(SPB)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .receive_enable(receive_enable),
    .read_ack(read_ack), .data_out(data_out), .character_received(character_received),
    .frame_error(frame_error), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct { int t; logic [7:0] b; logic fe; } ev_t;
  ev_t q[$];

  int   cyc = 0, checks = 0, errors = 0;
  bit   started = 0;
  logic [7:0] m_d;
  logic m_cr, m_fe, m_ov;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // reference model: outputs change only at scheduled byte arrivals, read_ack, or reset
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      q.delete();
      m_d <= 8'h00; m_cr <= 1'b0; m_fe <= 1'b0; m_ov <= 1'b0;
      started <= 1'b1;
    end else if (q.size() > 0 && q[0].t == cyc + 1) begin
      m_ov <= m_ov | m_cr;
      m_cr <= 1'b1;
      m_d  <= q[0].b;
      m_fe <= q[0].fe;
      void'(q.pop_front());
    end else if (read_ack) begin
      m_cr <= 1'b0;
      m_ov <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("data_out", {24'h0, data_out}, {24'h0, m_d});
      chk("character_received", {31'h0, character_received}, {31'h0, m_cr});
      chk("frame_error", {31'h0, frame_error}, {31'h0, m_fe});
      chk("overrun", {31'h0, overrun}, {31'h0, m_ov});
    end
  end

  // called #1 after a posedge; returns #1 after a posedge
  task automatic send(input logic [7:0] b, input logic stopb, input bit ack,
                      input int rst_at = -1, input int en_off = -1, input bit pin = 0);
    logic [9:0] fr;
    fr = {stopb, b, 1'b0};
    if (receive_enable) q.push_back('{cyc + LAT, b, ~stopb});
    for (int k = 0; k < FRAME_T; k++) begin
      if (pin && k == LAT - 1) chk("cr_before_latency", {31'h0, character_received}, 32'h0);
      if (pin && k == LAT)     chk("cr_at_latency", {31'h0, character_received}, 32'h1);
      data_in  = fr[k / BIT_T];
      rst      = (k == rst_at);
      read_ack = ack && (k == 310);
      if (k == en_off) receive_enable = 1'b0;
      @(posedge clk); #1;
    end
    rst = 1'b0; read_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    data_in = 1'b1; read_ack = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic ack();
    read_ack = 1'b1;
    @(posedge clk); #1;
    read_ack = 1'b0;
  endtask

  initial begin
    logic [7:0] word [4];
    logic [7:0] rb;
    logic       rs;
    bit         ra;
    word = '{8'h74, 8'h65, 8'h73, 8'h74};
    rst = 1'b1; data_in = 1'b1; receive_enable = 1'b1; read_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_data_out", {24'h0, data_out}, 32'h0);
    chk("reset_cr", {31'h0, character_received}, 32'h0);
    chk("reset_fe", {31'h0, frame_error}, 32'h0);
    chk("reset_ov", {31'h0, overrun}, 32'h0);
    idle(10);

    // single byte with exact-latency pin
    send(8'h74, 1'b1, 1'b0, -1, -1, 1'b1);
    chk("t1_data", {24'h0, data_out}, 32'h74);
    chk("t1_cr", {31'h0, character_received}, 32'h1);
    chk("t1_fe", {31'h0, frame_error}, 32'h0);
    ack();

    // back-to-back "test" with read_ack each
    for (int i = 0; i < 4; i++) send(word[i], 1'b1, 1'b1);
    chk("t2_data", {24'h0, data_out}, 32'h74);
    chk("t2_ov", {31'h0, overrun}, 32'h0);

    // overrun
    send(8'h65, 1'b1, 1'b0);
    send(8'h73, 1'b1, 1'b0);
    chk("t3_data", {24'h0, data_out}, 32'h73);
    chk("t3_ov", {31'h0, overrun}, 32'h1);
    ack(); idle(2);
    chk("t3_cr_cleared", {31'h0, character_received}, 32'h0);
    chk("t3_ov_cleared", {31'h0, overrun}, 32'h0);

    // framing error, then recovery
    send(8'hA5, 1'b0, 1'b0);
    chk("t4_data", {24'h0, data_out}, 32'hA5);
    chk("t4_fe", {31'h0, frame_error}, 32'h1);
    idle(16); ack();
    send(8'h5A, 1'b1, 1'b1);
    chk("t4_fe_clear", {31'h0, frame_error}, 32'h0);

    // short glitch on idle line
    idle(20);
    data_in = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    idle(120);
    chk("t5_glitch_cr", {31'h0, character_received}, 32'h0);

    // reset mid bit 4, then a clean frame
    send(8'hF3, 1'b1, 1'b0, 5 * BIT_T + BIT_T / 2);
    chk("t6_data_after_rst", {24'h0, data_out}, 32'h0);
    chk("t6_cr_after_rst", {31'h0, character_received}, 32'h0);
    send(8'h3C, 1'b1, 1'b0);
    chk("t6_data", {24'h0, data_out}, 32'h3C);
    ack();

    // enable dropped mid-frame: frame completes, next frame ignored
    send(8'hC3, 1'b1, 1'b1, -1, 100);
    send(8'h99, 1'b1, 1'b0);
    idle(20);
    chk("t7_data", {24'h0, data_out}, 32'hC3);
    receive_enable = 1'b1;

    // break: line held low for several frame times
    q.push_back('{cyc + LAT, 8'h00, 1'b1});
    data_in = 1'b0;
    repeat (3 * FRAME_T) begin @(posedge clk); #1; end
    idle(20);
    chk("t8_break_data", {24'h0, data_out}, 32'h0);
    chk("t8_break_fe", {31'h0, frame_error}, 32'h1);
    ack();

    // randomized frames
    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      ra = 1'($urandom_range(0, 1));
      send(rb, rs, ra);
      if (!rs) idle(16);
    end
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
